// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchronizer, centre-sampling FSM,
// level rdy/clr_rdy handshake with sticky overrun and one-cycle frame_err.
module uart_rx #(
  parameter int unsigned BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned CW = 12;
  localparam logic [CW-1:0] HALF_LOAD = CW'(BAUD_DIV / 2);
  localparam logic [CW-1:0] BIT_LOAD  = CW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [8:0]    shift_q, shift_d;
  logic          armed_q, armed_d;
  logic          rx_meta_q, rx_s_q;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rdy_q, rdy_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;
  logic          expire;

  assign expire    = (cnt_q == '0);
  assign rx_data   = rx_data_q;
  assign rdy       = rdy_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    armed_d   = armed_q;
    rx_data_d = rx_data_q;
    rdy_d     = rdy_q;
    ferr_d    = 1'b0;
    ovr_d     = ovr_q;

    if (clr_rdy) begin
      rdy_d = 1'b0;
      ovr_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (rx_s_q) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = START;
          cnt_d   = HALF_LOAD;
        end
      end
      START: begin
        if (!expire) begin
          cnt_d = cnt_q - CW'(1);
        end else if (!rx_s_q) begin
          state_d   = DATA;
          bit_cnt_d = '0;
          cnt_d     = BIT_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      DATA: begin
        if (!expire) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          shift_d   = {rx_s_q, shift_q[8:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          cnt_d     = BIT_LOAD;
          if (bit_cnt_q == 4'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (!expire) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = IDLE;
          // Completion overrides a same-cycle clr_rdy; overrun is dropped in that case.
          if (rx_s_q) begin
            rx_data_d = shift_q[8:1];
            rdy_d     = 1'b1;
            ovr_d     = (ovr_q | rdy_q) & ~clr_rdy;
          end else begin
            ferr_d  = 1'b1;
            armed_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      armed_q   <= 1'b1;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_data_q <= '0;
      rdy_q     <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      armed_q   <= armed_d;
      rx_meta_q <= RX;
      rx_s_q    <= rx_meta_q;
      rx_data_q <= rx_data_d;
      rdy_q     <= rdy_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table of framed bytes, hand-written corner
// sequences, then randomized frames against a transaction-level model.
module tb_uart_rx;
  localparam int unsigned B = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       RX;
  logic       clr_rdy;
  logic [7:0] rx_data;
  logic       rdy;
  logic       frame_err;
  logic       overrun;

  uart_rx #(.BAUD_DIV(B)) dut (
    .clk(clk), .rst(rst), .RX(RX), .clr_rdy(clr_rdy),
    .rx_data(rx_data), .rdy(rdy), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int pcyc = 0;
  int ferr_pulses = 0, ferr_run = 0, ferr_maxrun = 0;
  int rdy_rises = 0, last_rise = 0, rdy_hi = 0, ov_hi = 0;
  logic rdy_prev = 1'b0;

  always @(posedge clk) pcyc++;

  always @(negedge clk) begin
    if (frame_err === 1'b1) begin
      ferr_run++;
      if (ferr_run == 1) ferr_pulses++;
      if (ferr_run > ferr_maxrun) ferr_maxrun = ferr_run;
    end else begin
      ferr_run = 0;
    end
    if (rdy === 1'b1) begin
      rdy_hi++;
      if (rdy_prev !== 1'b1) begin
        rdy_rises++;
        last_rise = pcyc;
      end
    end
    if (overrun === 1'b1) ov_hi++;
    rdy_prev = rdy;
  end

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int got, input int lo, input int hi);
    checks++;
    if (got < lo || got > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clr();
    clr_rdy = 1'b1;
    tick(1);
    clr_rdy = 1'b0;
  endtask

  int start_cyc;

  // Frame on the line: start, 8 data LSB first, stop (good, or low for
  // low_bits bit times), then one bit time of idle high.
  task automatic send(input logic [7:0] d, input bit stop_ok, input int low_bits);
    RX = 1'b0;
    start_cyc = pcyc;
    tick(B);
    for (int i = 0; i < 8; i++) begin
      RX = d[i];
      tick(B);
    end
    if (stop_ok) begin
      RX = 1'b1;
      tick(B);
    end else begin
      RX = 1'b0;
      tick(low_bits * B);
      RX = 1'b1;
      tick(B);
    end
  endtask

  typedef struct {
    logic [7:0] d;
    bit         ok;
    bit         clr;
    logic [7:0] e_data;
    bit         e_rdy;
    bit         e_ov;
    int         e_ferr;
  } vec_t;

  vec_t vt[8];

  logic [7:0] m_data;
  bit m_rdy, m_ov;
  int f0, r0, h0, o0;

  initial begin
    vt[0] = '{8'h67, 1, 1, 8'h67, 1, 0, 0};
    vt[1] = '{8'h73, 1, 1, 8'h73, 1, 0, 0};
    vt[2] = '{8'h55, 1, 1, 8'h55, 1, 0, 0};
    vt[3] = '{8'hAA, 1, 0, 8'hAA, 1, 1, 0};
    vt[4] = '{8'h00, 0, 1, 8'hAA, 0, 0, 1};
    vt[5] = '{8'h67, 1, 0, 8'h67, 1, 0, 0};
    vt[6] = '{8'hFF, 1, 0, 8'hFF, 1, 1, 0};
    vt[7] = '{8'h80, 1, 1, 8'h80, 1, 0, 0};

    rst = 1'b1;
    RX = 1'b1;
    clr_rdy = 1'b0;
    @(negedge clk);
    tick(3);
    chk("reset rx_data", rx_data, 0);
    chk("reset rdy", rdy, 0);
    chk("reset frame_err", frame_err, 0);
    chk("reset overrun", overrun, 0);
    rst = 1'b0;
    tick(5);

    // First byte: latency from the start edge to rdy
    r0 = rdy_rises;
    f0 = ferr_pulses;
    send(8'h67, 1, 0);
    chk("latency rdy rises", rdy_rises - r0, 1);
    chk_rng("latency cycles", last_rise - start_cyc, 2 + B/2 + 9*B + 1 - 1, 2 + B/2 + 9*B + 1 + 1);
    chk("latency rx_data", rx_data, 8'h67);
    chk("latency no frame_err", ferr_pulses - f0, 0);

    foreach (vt[i]) begin
      if (vt[i].clr) pulse_clr();
      f0 = ferr_pulses;
      send(vt[i].d, vt[i].ok, 3);
      chk($sformatf("vec%0d rx_data", i), rx_data, vt[i].e_data);
      chk($sformatf("vec%0d rdy", i), rdy, vt[i].e_rdy);
      chk($sformatf("vec%0d overrun", i), overrun, vt[i].e_ov);
      chk($sformatf("vec%0d frame_err pulses", i), ferr_pulses - f0, vt[i].e_ferr);
    end

    // Short low glitch on an idle line must be rejected
    pulse_clr();
    r0 = rdy_rises;
    f0 = ferr_pulses;
    RX = 1'b0;
    tick(4);
    RX = 1'b1;
    tick(3 * B);
    chk("glitch rdy rises", rdy_rises - r0, 0);
    chk("glitch frame_err", ferr_pulses - f0, 0);
    send(8'h73, 1, 0);
    chk("after glitch rx_data", rx_data, 8'h73);
    chk("after glitch rdy", rdy, 1);

    // clr_rdy held across a completion: completion wins for one cycle
    clr_rdy = 1'b1;
    tick(2);
    r0 = rdy_rises;
    h0 = rdy_hi;
    o0 = ov_hi;
    send(8'h3C, 1, 0);
    clr_rdy = 1'b0;
    tick(1);
    chk("clr+done rdy rises", rdy_rises - r0, 1);
    chk("clr+done rdy high cycles", rdy_hi - h0, 1);
    chk("clr+done overrun cycles", ov_hi - o0, 0);
    chk("clr+done rx_data", rx_data, 8'h3C);
    chk("clr+done rdy final", rdy, 0);

    // Reset in the middle of the data bits
    send(8'h11, 1, 0);
    send(8'h22, 1, 0);
    chk("pre-reset overrun", overrun, 1);
    RX = 1'b0;
    tick(B);
    RX = 1'b1;
    tick(B + B/2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("midreset rx_data", rx_data, 0);
    chk("midreset rdy", rdy, 0);
    chk("midreset overrun", overrun, 0);
    chk("midreset frame_err", frame_err, 0);
    r0 = rdy_rises;
    f0 = ferr_pulses;
    tick(12 * B);
    chk("midreset no rdy", rdy_rises - r0, 0);
    chk("midreset no frame_err", ferr_pulses - f0, 0);
    send(8'h73, 1, 0);
    chk("after reset rx_data", rx_data, 8'h73);
    chk("after reset rdy", rdy, 1);

    // Randomized frames against a transaction-level model
    m_data = 8'h73;
    m_rdy = 1;
    m_ov = 0;
    for (int n = 0; n < 30; n++) begin
      logic [7:0] d;
      bit ok;
      int low;
      if ($urandom_range(1, 0) == 1) begin
        pulse_clr();
        m_rdy = 0;
        m_ov = 0;
      end
      d = 8'($urandom);
      ok = ($urandom_range(5, 0) != 0);
      low = $urandom_range(3, 1);
      f0 = ferr_pulses;
      send(d, ok, low);
      tick($urandom_range(2 * B, 0));
      if (ok) begin
        m_ov = m_ov | m_rdy;
        m_rdy = 1;
        m_data = d;
      end
      chk($sformatf("rand%0d rx_data", n), rx_data, m_data);
      chk($sformatf("rand%0d rdy", n), rdy, m_rdy);
      chk($sformatf("rand%0d overrun", n), overrun, m_ov);
      chk($sformatf("rand%0d frame_err", n), ferr_pulses - f0, ok ? 0 : 1);
    end

    chk("frame_err pulse width", ferr_maxrun, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-002 The block SHALL have parameter BAUD_DIV, default 2604, meaning clocks per bit (19200 baud at 50 MHz); legal range 16..4095.
REQ-003 The block SHALL have the following ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous active-high reset
- RX  input  1  asynchronous serial line; idle high; 8N1, LSB first
- clr_rdy  input  1  consumer acknowledge; clears rdy
- rx_data  output  8  last correctly framed byte
- rdy  output  1  byte available; level, held until cleared
- frame_err  output  1  one-cycle pulse; stop bit sampled low
- overrun  output  1  sticky; byte completed while rdy already set
REQ-004 The block SHALL feed the authentication block directly: rx_data is the command byte ('g' = 0x67, 's' = 0x73), and rdy/clr_rdy form the handshake.

Function
REQ-005 RX SHALL pass through two synchronizer flops (rx_s = second flop) before any use; both flops reset to 1.
REQ-006 The FSM SHALL have four states: IDLE, START, DATA, STOP.
REQ-007 In IDLE with rx_s==0 and armed==1, the FSM SHALL go to START and load the baud counter with BAUD_DIV/2 (integer division).
REQ-008 The baud counter SHALL count down once per clock; "expiry" means the clock on which it equals 0. On expiry it reloads BAUD_DIV-1 whenever the FSM stays outside IDLE.
REQ-009 START expiry:
- rx_s==0: go to DATA with bit_cnt=0.
- rx_s==1 (glitch): return to IDLE; no output changes.
REQ-010 DATA expiry: shift rx_s into the MSB of a 9-bit shift register (right shift) and increment bit_cnt. When bit_cnt reaches 8, go to STOP.
REQ-011 STOP expiry with rx_s==1:
- load rx_data from the shift register;
- set rdy=1;
- set overrun=1 if rdy was already 1 on that cycle;
- go to IDLE.
REQ-012 STOP expiry with rx_s==0:
- pulse frame_err for exactly one cycle;
- leave rx_data and rdy unchanged;
- clear armed;
- go to IDLE.
REQ-013 armed SHALL be set whenever rx_s==1 in IDLE. After a framing error (break condition), no new frame starts until the line has been seen high.
REQ-014 clr_rdy==1 SHALL clear rdy and overrun on the next edge.
REQ-015 When clr_rdy and byte completion (REQ-011) occur on the same cycle, completion SHALL win: rdy=1, overrun=0, rx_data = new byte.
REQ-016 rdy SHALL assert exactly 2 + BAUD_DIV/2 + 9*BAUD_DIV + 1 clocks (±1) after the RX falling edge.
REQ-017 RX is ignored during DATA except at sample points; no mid-frame resynchronization.
REQ-018 bit_cnt SHALL be 4 bits wide and the shift register 9 bits wide; no other arithmetic is needed.

Reset
REQ-019 rst==1 SHALL force on the next edge, regardless of state (including mid-frame):
- FSM=IDLE, bit_cnt=0, counter=0, armed=1;
- sync flops=1, rx_data=0x00;
- rdy=0, frame_err=0, overrun=0.
REQ-020 A frame interrupted by reset SHALL NOT produce rdy. Reception resumes with the next falling edge after rst deasserts.

Verification
REQ-021 With BAUD_DIV=16, send 0x67 (8N1) -> rdy rises 2+8+144+1 clocks (±1) after the start edge; rx_data==0x67; frame_err never pulses.
REQ-022 Loopback UART_tx -> uart_rx at default BAUD_DIV: send 0x67 then 0x73, pulsing clr_rdy after each -> rx_data==0x67, then 0x73; overrun==0 throughout.
REQ-023 Send two bytes, 0x55 then 0xAA, without clr_rdy -> rx_data==0xAA, rdy==1, overrun==1; one clr_rdy pulse -> rdy==0 and overrun==0.
REQ-024 With BAUD_DIV=16, drive a 4-clock low glitch on idle RX -> no rdy and no frame_err; a following valid 0x73 is received correctly.
REQ-025 Send 0x00 with the stop bit held low for 3 bit times, then RX high -> frame_err one-cycle pulse; rdy stays 0; a following 0x67 is received correctly.
REQ-026 Assert rst for 1 cycle in the middle of the DATA bits of 0x67 -> all outputs 0 next cycle; no rdy for that frame; the next full 0x73 frame gives rx_data==0x73.
